// File: rtl/nibble_record_writer.sv
// rtl/nibble_record_writer.sv - packs (V,T) records as four BCD nibbles into a 256x4 RAM
// Define RW_WRAP_EN for circular overwrite with a one-clock full pulse instead of sticky full.
module nibble_record_writer #(
   parameter int NREC = 64,
   parameter int BASE = 0
) (
   input  logic       clock,
   input  logic       reset_,
   input  logic       dav_,
   output logic       rfd,
   input  logic [6:0] v,
   input  logic [6:0] t,
   output logic [7:0] addr,
   output logic [3:0] data,
   output logic       s_,
   output logic       mw_,
   output logic       full
);

   localparam logic [6:0] NREC_W = 7'(NREC);
   localparam logic [7:0] BASE_A = 8'(BASE);

   typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} state_t;

   state_t      state, next_state;
   logic [1:0]  idx;
   logic [6:0]  count;
   logic [15:0] buffer;
   logic        last_rec;

   // Out-of-range operands clamp to 99 so every nibble is a legal BCD digit.
   function automatic logic [7:0] to_bcd(input logic [6:0] x);
      logic [6:0] c;
      c = (x > 7'd99) ? 7'd99 : x;
      return {4'(c / 7'd10), 4'(c % 7'd10)};
   endfunction

   assign last_rec = (idx == 2'd3) && ((count + 7'd1) == NREC_W);

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) state <= S0;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S0: if (!dav_) next_state = S1;
         S1: if (dav_)  next_state = S2;
         S2: next_state = S3;
         S3: next_state = S4;
         S4: begin
            if (idx != 2'd3) next_state = S2;
`ifdef RW_WRAP_EN
            else             next_state = S0;
`else
            else if (last_rec) next_state = S5;
            else               next_state = S0;
`endif
         end
         S5: next_state = S5;
         default: next_state = S0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         rfd    <= 1'b1;
         s_     <= 1'b1;
         mw_    <= 1'b1;
         addr   <= BASE_A;
         data   <= 4'd0;
         full   <= 1'b0;
         count  <= 7'd0;
         idx    <= 2'd0;
         buffer <= 16'd0;
      end else begin
`ifdef RW_WRAP_EN
         full <= 1'b0;
`endif
         case (state)
            S0: begin
               rfd <= 1'b1;
               if (!dav_) begin
                  buffer <= {to_bcd(t), to_bcd(v)};
                  rfd    <= 1'b0;
               end
            end
            S1: rfd <= 1'b0;
            S2: begin
               data <= buffer[{idx, 2'b00} +: 4];
               s_   <= 1'b0;
               mw_  <= 1'b1;
            end
            S3: mw_ <= 1'b0;
            S4: begin
               mw_  <= 1'b1;
               s_   <= 1'b1;
               addr <= addr + 8'd1;
               idx  <= idx + 2'd1;
               if (idx == 2'd3) begin
                  count <= count + 7'd1;
                  if (last_rec) begin
                     full <= 1'b1;
`ifdef RW_WRAP_EN
                     count <= 7'd0;
                     addr  <= BASE_A;
                     rfd   <= 1'b1;
`endif
                  end else begin
                     rfd <= 1'b1;
                  end
               end
            end
            S5: begin
               full <= 1'b1;
               rfd  <= 1'b0;
               s_   <= 1'b1;
               mw_  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
